// File: rtl/mul_pkg.sv
// Shared types for the multiplier path (issue stage, multiplier core, result stage).
//   mul_op_e   : RISC-V style multiply variant as presented by execute.
//   mul_prep_t : prepared operand fields. The request tag travels beside this
//                struct because its width is a per-instance parameter.
//   abs32      : 32-bit two's-complement magnitude.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        neg;
    logic        hi;
  } mul_prep_t;

  // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_issue_fifo.sv
// Generic DEPTH-entry synchronous FIFO with registered storage.
// Ports:
//   clk, sclr          : clock, synchronous active-high clear (storage cleared too)
//   push_i, wdata_i    : write strobe and data (caller guarantees !full_o)
//   pop_i              : read strobe (caller guarantees !empty_o)
//   rdata_o            : head entry, stable until popped
//   full_o, empty_o    : occupancy flags
//   count_o            : occupancy
module mul_issue_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (pop_i && !push_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mul_issue.sv
// Operand-preparation and issue stage in front of the unsigned 32x32 multiplier.
// Decodes the multiply variant, converts signed operands to magnitudes, records
// negate/high-half flags, buffers prepared requests and issues them in order.
// Ports:
//   CLK, SCLR                         : clock, synchronous active-high reset
//   in_valid/in_ready                 : request handshake from execute
//   in_op, in_a, in_b, in_tag         : variant, raw operands, opaque tag
//   out_valid/out_ready               : issue handshake to multiplier core
//   out_a, out_b, out_neg, out_hi     : prepared head entry
//   out_tag                           : tag of head entry
//   count                             : FIFO occupancy
module mul_issue
  import mul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                   CLK,
  input  logic                   SCLR,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_a,
  output logic [31:0]            out_b,
  output logic                   out_neg,
  output logic                   out_hi,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int EW = $bits(mul_prep_t) + TAG_W;

  mul_prep_t      prep, head;
  logic [EW-1:0]  rdata;
  logic           full, empty, push, pop;

  always_comb begin
    prep = '0;
    case (mul_op_e'(in_op))
      OP_MUL: begin
        prep.a = in_a;
        prep.b = in_b;
      end
      OP_MULH: begin
        prep.a   = abs32(in_a);
        prep.b   = abs32(in_b);
        prep.neg = in_a[31] ^ in_b[31];
        prep.hi  = 1'b1;
      end
      OP_MULHSU: begin
        prep.a   = abs32(in_a);
        prep.b   = in_b;
        prep.neg = in_a[31];
        prep.hi  = 1'b1;
      end
      default: begin
        prep.a  = in_a;
        prep.b  = in_b;
        prep.hi = 1'b1;
      end
    endcase
    // A zero product must never be negated downstream.
    if (in_a == '0 || in_b == '0) prep.neg = 1'b0;
  end

  // Both handshakes are held off during the reset cycle.
  assign in_ready  = !SCLR && !full;
  assign out_valid = !SCLR && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  mul_issue_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk    (CLK),
    .sclr   (SCLR),
    .push_i (push),
    .wdata_i({in_tag, prep}),
    .pop_i  (pop),
    .rdata_o(rdata),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  assign {out_tag, head} = rdata;
  assign out_a   = head.a;
  assign out_b   = head.b;
  assign out_neg = head.neg;
  assign out_hi  = head.hi;

endmodule

// File: tb/tb_mul_issue.sv
module tb_mul_issue;

  logic        CLK = 1'b0;
  logic        SCLR;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic        out_neg, out_hi;
  logic [3:0]  out_tag;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mul_issue #(.DEPTH(2), .TAG_W(4)) dut (
    .CLK      (CLK),
    .SCLR     (SCLR),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_neg  (out_neg),
    .out_hi   (out_hi),
    .out_tag  (out_tag),
    .count    (count)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  tag;
    logic [31:0] ea, eb;
    logic        en, eh;
  } vec_t;

  // Reference decode written from the arithmetic definition: {a, b, neg, hi}.
  function automatic logic [65:0] ref_dec(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] ma, mb;
    logic neg, hi;
    sa = a; sb = b;
    ma = (sa < 0) ? 32'(0 - a) : a;
    mb = (sb < 0) ? 32'(0 - b) : b;
    hi = (op != 2'd0);
    case (op)
      2'd1:    begin neg = (sa < 0) != (sb < 0); return {ma, mb, (a != 0 && b != 0) ? neg : 1'b0, hi}; end
      2'd2:    begin neg = (sa < 0);             return {ma, b,  (a != 0 && b != 0) ? neg : 1'b0, hi}; end
      default: return {a, b, 1'b0, hi};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
  endtask

  task automatic test_reset();
    SCLR = 1'b1; out_ready = 1'b1;
    drive(1'b1, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 4'hA);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_during: got %b expected 0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_during: got %b expected 0", out_valid); end
    SCLR = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 2'd0}) begin
      n_err++; $display("FAIL reset_flags: got rdy=%b vld=%b cnt=%0d expected rdy=1 vld=0 cnt=0", in_ready, out_valid, count);
    end
    n_cmp++;
    if ({out_a, out_b, out_neg, out_hi, out_tag} !== 70'h0) begin
      n_err++; $display("FAIL reset_data: got a=%h b=%h n=%b h=%b t=%h expected all 0", out_a, out_b, out_neg, out_hi, out_tag);
    end
  endtask

  task automatic test_decode();
    vec_t v [8];
    v[0] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0003, 4'h5, 32'h0000_0001, 32'h0000_0003, 1'b1, 1'b1};
    v[1] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'h6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1};
    v[2] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'h7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1};
    v[3] = '{2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 4'h8, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0};
    v[4] = '{2'd1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h9, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1};
    v[5] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 4'hA, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1};
    v[6] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFF, 4'hB, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 1'b1};
    v[7] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 4'hC, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      drive(1'b1, v[i].op, v[i].a, v[i].b, v[i].tag);
      @(posedge CLK);
      @(negedge CLK);
      drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
      n_cmp++;
      if ({out_valid, out_a, out_b, out_neg, out_hi, out_tag} !==
          {1'b1, v[i].ea, v[i].eb, v[i].en, v[i].eh, v[i].tag}) begin
        n_err++;
        $display("FAIL decode_%0d: got v=%b a=%h b=%h n=%b h=%b t=%h expected v=1 a=%h b=%h n=%b h=%b t=%h",
                 i, out_valid, out_a, out_b, out_neg, out_hi, out_tag,
                 v[i].ea, v[i].eb, v[i].en, v[i].eh, v[i].tag);
      end
      @(posedge CLK);
      @(negedge CLK);
      n_cmp++;
      if ({count, out_valid} !== {2'd0, 1'b0}) begin
        n_err++; $display("FAIL decode_drain_%0d: got cnt=%0d vld=%b expected cnt=0 vld=0", i, count, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge CLK);
    out_ready = 1'b0;
    drive(1'b1, 2'd3, 32'h0000_0011, 32'h0000_0022, 4'h1);
    @(posedge CLK); @(negedge CLK);
    drive(1'b1, 2'd3, 32'h0000_0033, 32'h0000_0044, 4'h2);
    @(posedge CLK); @(negedge CLK);
    drive(1'b1, 2'd3, 32'h0000_0055, 32'h0000_0066, 4'h3);
    #1;
    n_cmp++;
    if ({in_ready, count, out_tag, out_a} !== {1'b0, 2'd2, 4'h1, 32'h0000_0011}) begin
      n_err++; $display("FAIL bp_full: got rdy=%b cnt=%0d tag=%h a=%h expected rdy=0 cnt=2 tag=1 a=00000011", in_ready, count, out_tag, out_a);
    end
    @(posedge CLK); @(negedge CLK);
    n_cmp++;
    if ({in_ready, count, out_valid, out_tag, out_a, out_b} !== {1'b0, 2'd2, 1'b1, 4'h1, 32'h0000_0011, 32'h0000_0022}) begin
      n_err++; $display("FAIL bp_hold: got rdy=%b cnt=%0d vld=%b tag=%h a=%h b=%h expected rdy=0 cnt=2 vld=1 tag=1 a=00000011 b=00000022",
                        in_ready, count, out_valid, out_tag, out_a, out_b);
    end
    out_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    n_cmp++;
    if ({in_ready, count, out_tag, out_a} !== {1'b1, 2'd1, 4'h2, 32'h0000_0033}) begin
      n_err++; $display("FAIL bp_pop1: got rdy=%b cnt=%0d tag=%h a=%h expected rdy=1 cnt=1 tag=2 a=00000033", in_ready, count, out_tag, out_a);
    end
    @(posedge CLK); @(negedge CLK);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    n_cmp++;
    if ({out_valid, count, out_tag, out_a} !== {1'b1, 2'd1, 4'h3, 32'h0000_0055}) begin
      n_err++; $display("FAIL bp_pop2: got vld=%b cnt=%0d tag=%h a=%h expected vld=1 cnt=1 tag=3 a=00000055", out_valid, count, out_tag, out_a);
    end
    @(posedge CLK); @(negedge CLK);
    n_cmp++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      n_err++; $display("FAIL bp_drain: got vld=%b cnt=%0d expected vld=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] exp_q [$];
    logic [3:0]  tag_q [$];
    logic [65:0] e;
    logic [3:0]  et;
    logic [1:0]  op;
    logic [31:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        e  = exp_q.pop_front();
        et = tag_q.pop_front();
        n_cmp++;
        if ({out_valid, out_a, out_b, out_neg, out_hi, out_tag} !== {1'b1, e, et} || count > 2'd1) begin
          n_err++;
          $display("FAIL b2b_%0d: got v=%b a=%h b=%h n=%b h=%b t=%h cnt=%0d expected v=1 a=%h b=%h n=%b h=%b t=%h cnt<=1",
                   i - 1, out_valid, out_a, out_b, out_neg, out_hi, out_tag, count,
                   e[65:34], e[33:2], e[1], e[0], et);
        end
      end
      if (i < 16) begin
        op = 2'($urandom_range(0, 3));
        a  = (i % 5 == 2) ? 32'h0 : $urandom;
        b  = (i % 7 == 3) ? 32'h0 : $urandom;
        if (i % 4 == 1) a[31] = 1'b1;
        drive(1'b1, op, a, b, 4'(i));
        exp_q.push_back(ref_dec(op, a, b));
        tag_q.push_back(4'(i));
      end else begin
        drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
      end
      @(posedge CLK);
    end
    @(negedge CLK);
    n_cmp++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      n_err++; $display("FAIL b2b_drain: got vld=%b cnt=%0d expected vld=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_sclr();
    @(negedge CLK);
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 32'hFFFF_FFF0, 32'h0000_0005, 4'h7);
    @(posedge CLK); @(negedge CLK);
    drive(1'b1, 2'd0, 32'h0000_0123, 32'h0000_0456, 4'h8);
    @(posedge CLK); @(negedge CLK);
    n_cmp++;
    if (count !== 2'd2) begin n_err++; $display("FAIL sclr_prefill: got cnt=%0d expected 2", count); end
    SCLR = 1'b1;
    drive(1'b1, 2'd3, 32'h0000_0999, 32'h0000_0888, 4'h9);
    #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_err++; $display("FAIL sclr_cycle: got rdy=%b vld=%b expected rdy=0 vld=0", in_ready, out_valid);
    end
    @(posedge CLK); @(negedge CLK);
    SCLR = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1;
    n_cmp++;
    if ({count, out_valid, out_a, out_b, out_neg, out_hi, out_tag} !== 73'h0) begin
      n_err++; $display("FAIL sclr_clear: got cnt=%0d vld=%b a=%h b=%h n=%b h=%b t=%h expected all 0",
                        count, out_valid, out_a, out_b, out_neg, out_hi, out_tag);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      n_cmp++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
        n_err++; $display("FAIL sclr_dropped_%0d: got vld=%b cnt=%0d tag=%h expected vld=0 cnt=0", i, out_valid, count, out_tag);
      end
    end
  endtask

  initial begin
    SCLR = 1'b1; out_ready = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_sclr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
